// File: rtl/modexp_stream_io.sv
// modexp_stream_io: streams m/e/n words into an exponentiator and streams its result back out
module modexp_stream_io #(
  parameter int W = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         exp_start,
  input  logic         exp_ready,
  output logic [W-1:0] exp_m,
  output logic [W-1:0] exp_e,
  output logic [W-1:0] exp_n,
  input  logic [W-1:0] exp_c,
  output logic         busy
);
  localparam int NW = W / 32;
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;
  state_t state, state_n;
  logic [IW-1:0] widx;
  logic [1:0] sel;
  logic seen_busy;
  logic [W-1:0] res;
  logic in_fire, out_fire, wrap, done;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign wrap     = widx == LAST;
  assign done     = state == WAIT && exp_ready && seen_busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else state <= state_n;
  always_comb
    state_n = (state == LOAD && in_fire && wrap && sel == 2'd2) ? START :
              (state == START && exp_start)                     ? WAIT :
              done                                              ? UNLOAD :
              (state == UNLOAD && out_fire && out_last)         ? LOAD : state;
  always_comb begin
    in_ready  = state == LOAD;
    busy      = state != LOAD;
    exp_start = state == START && exp_ready;
    out_valid = state == UNLOAD;
    out_data  = res[32*widx +: 32];
    out_last  = out_valid && wrap;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      widx      <= '0;
      sel       <= '0;
      seen_busy <= 1'b0;
      exp_m     <= '0;
      exp_e     <= '0;
      exp_n     <= '0;
      res       <= '0;
    end else begin
      if (in_fire) begin
        sel <= !wrap ? sel : (sel == 2'd2 ? 2'd0 : sel + 2'd1);
        if (sel == 2'd0) exp_m[32*widx +: 32] <= in_data;
        if (sel == 2'd1) exp_e[32*widx +: 32] <= in_data;
        if (sel == 2'd2) exp_n[32*widx +: 32] <= in_data;
      end
      if (in_fire || out_fire) widx <= wrap ? '0 : widx + 1'b1;
      // the exponentiator may still report ready on entry, so completion needs a busy cycle first
      seen_busy <= state == START ? 1'b0 : (seen_busy || !exp_ready);
      if (done) begin
        res  <= exp_c;
        widx <= '0;
      end
    end
endmodule

// File: doc/modexp_stream_io.md
MODEXP_STREAM_IO -- requirements
Module: modexp_stream_io

Interface
REQ-001 SHALL have parameter W, default 2048, operand width in bits; legal values are multiples of 32 and at least 64.
REQ-002 SHALL have localparam NW = W/32, the number of 32-bit words per operand.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  loader accepts a word; a transfer occurs on a clk edge where in_valid && in_ready.
REQ-007 in_data  input  32  operand word.
REQ-008 out_valid  output  1  result word valid.
REQ-009 out_ready  input  1  downstream accepts; a transfer occurs on a clk edge where out_valid && out_ready.
REQ-010 out_data  output  32  result word.
REQ-011 out_last  output  1  high with the final result word, NW-1.
REQ-012 exp_start  output  1  start pulse to the exponentiator.
REQ-013 exp_ready  input  1  exponentiator idle/done flag; high when idle.
REQ-014 exp_m, exp_e, exp_n  output  W each  operand registers driven to the exponentiator.
REQ-015 exp_c  input  W  exponentiator result.
REQ-016 busy  output  1  high in every state except LOAD.

Function
REQ-017 SHALL implement FSM states LOAD, START, WAIT, UNLOAD.
REQ-018 LOAD behaviour:
- in_ready = 1.
- Each accepted word is written into operand sel (0 = m, 1 = e, 2 = n) at bits [32*widx+31 : 32*widx]; the least-significant word arrives first.
REQ-019 Counter widx SHALL increment per accepted word and wrap from NW-1 to 0, incrementing sel at the wrap; the wrap at sel = 2 moves the FSM to START and clears sel.
REQ-020 in_ready SHALL be 0 in START, WAIT and UNLOAD; in_valid is ignored there.
REQ-021 START behaviour:
- exp_start = exp_ready, combinationally.
- The FSM moves to WAIT on the edge where exp_start = 1, so exp_start is high for exactly one cycle per job.
- The FSM stays in START while exp_ready = 0.
REQ-022 WAIT behaviour:
- Flag seen_busy clears on entry and sets on any cycle with exp_ready = 0.
- Completion is a cycle with exp_ready = 1 && seen_busy = 1.
- At completion, exp_c is captured into a result register and the FSM moves to UNLOAD with widx = 0.
REQ-023 WAIT SHALL tolerate a one-cycle busy window (the m = 0 case: ready low for one cycle, result 0).
REQ-024 UNLOAD behaviour:
- out_valid = 1.
- out_data = result[32*widx+31 : 32*widx].
- out_last = (widx == NW-1).
- widx increments per transfer.
- The transfer with out_last moves the FSM to LOAD with widx = 0.
REQ-025 While out_ready = 0 in UNLOAD, out_data and out_last SHALL hold stable.
REQ-026 out_valid SHALL be 0 outside UNLOAD.
REQ-027 exp_m, exp_e and exp_n SHALL change only on LOAD transfers and hold through START, WAIT and UNLOAD.
REQ-028 Latency SHALL be:
- First result word valid one cycle after the completion cycle.
- Last input transfer to exp_start high: one cycle, when exp_ready = 1.
REQ-029 Throughput SHALL be one word per cycle in LOAD and in UNLOAD under continuous valid/ready.
REQ-030 No arithmetic on operands; widx width SHALL be clog2(NW), and sel 2 bits.

Reset
REQ-031 On rst high, the block SHALL asynchronously enter the following state, regardless of current state, including mid-load, WAIT, or mid-unload:
- state = LOAD.
- widx = 0, sel = 0, seen_busy = 0.
- exp_m, exp_e, exp_n and the result register = 0.
- exp_start = 0, out_valid = 0, out_last = 0, out_data = 0.
- in_ready = 1 after release; busy = 0.
REQ-032 After mid-operation reset, the next accepted word SHALL be treated as m word 0.

Verification (W = 64, NW = 2, behavioural exponentiator model)
REQ-033 Basic job: load m = 4, e = 13, n = 497 (six words, LSW first) -> single exp_start pulse; out words 0x000001BD, 0x00000000; out_last on the second word.
REQ-034 m = 0, e = 5, n = 7 -> model ready low for one cycle only; WAIT completes; outputs 0, 0.
REQ-035 Backpressure: out_ready toggles 1,0,0,1 -> word 0 once and word 1 held stable for two cycles then transferred; no duplicate or lost words.
REQ-036 Start gating: exp_ready held 0 for 5 cycles after load -> exp_start stays 0, then pulses exactly one cycle once ready rises.
REQ-037 Reset mid-WAIT, then reload m = 3, e = 5, n = 7 -> no output from the aborted job; result words 0x00000005, 0x00000000.
REQ-038 Gapped input: in_valid low on alternate cycles -> operand registers identical to a gap-free load; in_ready low throughout WAIT.
